// File: rtl/universal_shift_register.sv
// universal_shift_register: WIDTH-bit clocked register with load, shift, rotate and up-count modes
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (q = RESET_VAL, flags cleared)
//   en         operation enable; when low q and serial-out flags hold, carry clears
//   mode       000 hold, 001 load, 010 shl, 011 shr, 100 rotl, 101 rotr, 110 ashr, 111 inc
//   d          parallel load data
//   ser_l      serial input entering bit 0 on shl
//   ser_r      serial input entering the MSB on shr
//   q          registered contents
//   q_not      bitwise complement of q
//   ser_out_l  bit last shifted out of the MSB by shl/rotl
//   ser_out_r  bit last shifted out of the LSB by shr/rotr/ashr
//   carry      one-cycle pulse when inc wraps from all-ones to zero
//   zero       high when q is zero
module universal_shift_register #(
    parameter int          WIDTH     = 8,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_l,
    input  logic             ser_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_not,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             carry,
    output logic             zero
);
    logic [WIDTH-1:0] q_nxt;
    logic             sol_nxt;
    logic             sor_nxt;
    logic             carry_nxt;

    // Unlisted (including undefined) mode values fall to the default and hold.
    always_comb begin
        q_nxt     = q;
        sol_nxt   = ser_out_l;
        sor_nxt   = ser_out_r;
        carry_nxt = 1'b0;
        if (en) begin
            case (mode)
                3'b001: q_nxt = d;
                3'b010: begin
                    q_nxt   = {q[WIDTH-2:0], ser_l};
                    sol_nxt = q[WIDTH-1];
                end
                3'b011: begin
                    q_nxt   = {ser_r, q[WIDTH-1:1]};
                    sor_nxt = q[0];
                end
                3'b100: begin
                    q_nxt   = {q[WIDTH-2:0], q[WIDTH-1]};
                    sol_nxt = q[WIDTH-1];
                end
                3'b101: begin
                    q_nxt   = {q[0], q[WIDTH-1:1]};
                    sor_nxt = q[0];
                end
                3'b110: begin
                    q_nxt   = {q[WIDTH-1], q[WIDTH-1:1]};
                    sor_nxt = q[0];
                end
                3'b111: begin
                    q_nxt     = q + WIDTH'(1);
                    carry_nxt = &q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q         <= RESET_VAL[WIDTH-1:0];
            ser_out_l <= 1'b0;
            ser_out_r <= 1'b0;
            carry     <= 1'b0;
        end else begin
            q         <= q_nxt;
            ser_out_l <= sol_nxt;
            ser_out_r <= sor_nxt;
            carry     <= carry_nxt;
        end
    end

    assign q_not = ~q;
    assign zero  = (q == '0);
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: scoreboard bench for 8-bit and 4-bit register instances
module tb_universal_shift_register;
    localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, SHL = 3'd2, SHR = 3'd3,
                           ROTL = 3'd4, ROTR = 3'd5, ASHR = 3'd6, INC = 3'd7;

    typedef struct {
        logic [31:0] q;
        logic        sol;
        logic        sor;
        logic        c;
    } st_t;

    logic       clk = 1'b0;
    logic       rst, en, ser_l, ser_r;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q8, qn8;
    logic [3:0] q4, qn4;
    logic       sol8, sor8, c8, z8, sol4, sor4, c4, z4;

    int  passed = 0;
    int  total  = 0;
    st_t m8, m4;
    st_t sb8[$];
    st_t sb4[$];

    always #5 clk = ~clk;

    universal_shift_register #(.WIDTH(8), .RESET_VAL(32'hA5)) dut8 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d), .ser_l(ser_l), .ser_r(ser_r),
        .q(q8), .q_not(qn8), .ser_out_l(sol8), .ser_out_r(sor8), .carry(c8), .zero(z8)
    );

    universal_shift_register #(.WIDTH(4), .RESET_VAL(32'hA5)) dut4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d[3:0]), .ser_l(ser_l), .ser_r(ser_r),
        .q(q4), .q_not(qn4), .ser_out_l(sol4), .ser_out_r(sor4), .carry(c4), .zero(z4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else passed++;
    endtask

    function automatic st_t model(input st_t s, input int w, input logic [31:0] rv);
        st_t         n = s;
        logic [31:0] mask = (32'd1 << w) - 32'd1;
        logic        msb = s.q[w-1];
        logic        lsb = s.q[0];
        n.c = 1'b0;
        if (rst) begin
            n.q = rv & mask;
            n.sol = 1'b0;
            n.sor = 1'b0;
        end else if (en) begin
            case (mode)
                LOAD: n.q = {24'd0, d} & mask;
                SHL:  begin n.q = ((s.q << 1) | {31'd0, ser_l}) & mask; n.sol = msb; end
                SHR:  begin n.q = (s.q >> 1) | ({31'd0, ser_r} << (w - 1)); n.sor = lsb; end
                ROTL: begin n.q = ((s.q << 1) | {31'd0, msb}) & mask; n.sol = msb; end
                ROTR: begin n.q = (s.q >> 1) | ({31'd0, lsb} << (w - 1)); n.sor = lsb; end
                ASHR: begin n.q = (s.q >> 1) | ({31'd0, msb} << (w - 1)); n.sor = lsb; end
                INC:  begin n.c = (s.q == mask); n.q = (s.q + 32'd1) & mask; end
                default: ;
            endcase
        end
        return n;
    endfunction

    // Predict from the inputs present just before the edge, then compare after it.
    task automatic commit();
        st_t e;
        m8 = model(m8, 8, 32'hA5);
        m4 = model(m4, 4, 32'hA5);
        sb8.push_back(m8);
        sb4.push_back(m4);
        @(posedge clk);
        #1;
        e = sb8.pop_front();
        check("q8", {24'd0, q8}, e.q);
        check("qn8", {24'd0, qn8}, ~e.q & 32'hFF);
        check("sol8", {31'd0, sol8}, {31'd0, e.sol});
        check("sor8", {31'd0, sor8}, {31'd0, e.sor});
        check("c8", {31'd0, c8}, {31'd0, e.c});
        check("z8", {31'd0, z8}, {31'd0, e.q == 0});
        e = sb4.pop_front();
        check("q4", {28'd0, q4}, e.q);
        check("qn4", {28'd0, qn4}, ~e.q & 32'hF);
        check("sol4", {31'd0, sol4}, {31'd0, e.sol});
        check("sor4", {31'd0, sor4}, {31'd0, e.sor});
        check("c4", {31'd0, c4}, {31'd0, e.c});
        check("z4", {31'd0, z4}, {31'd0, e.q == 0});
    endtask

    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] dv, input logic sl, input logic sr);
        @(negedge clk);
        rst = r; en = e; mode = m; d = dv; ser_l = sl; ser_r = sr;
        commit();
    endtask

    initial begin
        m8 = '{32'd0, 1'b0, 1'b0, 1'b0};
        m4 = '{32'd0, 1'b0, 1'b0, 1'b0};
        rst = 1'b1; en = 1'b1; mode = LOAD; d = 8'hFF; ser_l = 1'b0; ser_r = 1'b0;
        step(1, 1, LOAD, 8'hFF, 0, 0);
        step(1, 1, LOAD, 8'hFF, 0, 0);
        check("rst_q", {24'd0, q8}, 32'hA5);
        check("rst_qn", {24'd0, qn8}, 32'h5A);
        check("rst_q4_trunc", {28'd0, q4}, 32'h5);
        step(0, 1, LOAD, 8'h3C, 0, 0);
        check("load_q", {24'd0, q8}, 32'h3C);
        step(0, 0, LOAD, 8'h00, 0, 0);
        check("en0_hold", {24'd0, q8}, 32'h3C);
        @(negedge clk);
        en = 1'b1; mode = LOAD; d = 8'h11;
        #2;
        check("no_transp", {24'd0, q8}, 32'h3C);
        d = 8'h22;
        commit();
        check("late_d", {24'd0, q8}, 32'h22);
        step(0, 1, LOAD, 8'h81, 0, 0);
        step(0, 1, SHL, 8'h00, 0, 0);
        check("shl_q", {24'd0, q8}, 32'h02);
        check("shl_sol", {31'd0, sol8}, 32'd1);
        step(0, 1, SHR, 8'h00, 0, 1);
        check("shr_q", {24'd0, q8}, 32'h81);
        step(0, 1, ASHR, 8'h00, 0, 0);
        check("ashr_q", {24'd0, q8}, 32'hC0);
        check("ashr_sor", {31'd0, sor8}, 32'd1);
        step(0, 1, LOAD, 8'h81, 0, 0);
        step(0, 1, ROTL, 8'h00, 0, 0);
        check("rotl_q", {24'd0, q8}, 32'h03);
        step(0, 1, ROTR, 8'h00, 0, 0);
        check("rotr1_q", {24'd0, q8}, 32'h81);
        step(0, 1, ROTR, 8'h00, 0, 0);
        check("rotr2_q", {24'd0, q8}, 32'hC0);
        step(0, 1, LOAD, 8'hFE, 0, 0);
        step(0, 1, INC, 8'h00, 0, 0);
        check("inc_ff", {24'd0, q8}, 32'hFF);
        check("inc_c0", {31'd0, c8}, 32'd0);
        check("inc4_f", {28'd0, q4}, 32'hF);
        step(0, 1, INC, 8'h00, 0, 0);
        check("wrap_c", {31'd0, c8}, 32'd1);
        check("wrap_z", {31'd0, z8}, 32'd1);
        check("wrap4_c", {31'd0, c4}, 32'd1);
        step(0, 1, INC, 8'h00, 0, 0);
        check("inc_01", {24'd0, q8}, 32'h01);
        check("c_pulse", {31'd0, c8}, 32'd0);
        step(0, 1, 3'bxxx, 8'h55, 1, 1);
        check("xmode_hold", {24'd0, q8}, 32'h01);
        step(0, 1, SHL, 8'h00, 1, 0);
        step(0, 1, SHL, 8'h00, 1, 0);
        step(1, 1, SHL, 8'h00, 1, 0);
        check("midrst_q", {24'd0, q8}, 32'hA5);
        check("midrst_sol", {31'd0, sol8}, 32'd0);
        step(0, 1, SHL, 8'h00, 0, 0);
        check("resume_q", {24'd0, q8}, 32'h4A);
        check("resume_sol", {31'd0, sol8}, 32'd1);
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
